// File: rtl/bitcoin_nonce_select.sv
// Scans NUM_NONCES H0 words from memory, keeps the minimum and its index, and
// writes a {found, nonce} summary word back through the same memory port.
module bitcoin_nonce_select #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [7:0] LastIdx = 8'(NUM_NONCES - 1);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StFin} state_t;

  state_t      state_q;
  logic [7:0]  iss_q;        // index of the address currently on mem_addr
  logic        v1_q, v2_q;   // read-latency pipeline valid bits
  logic [7:0]  idx2_q;
  logic [15:0] result_addr_q;
  logic [31:0] target_q;
  logic        found_next;

  assign mem_clk    = clk;
  assign found_next = best_hash < target_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      iss_q          <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      idx2_q         <= '0;
      result_addr_q  <= '0;
      target_q       <= '0;
      done           <= 1'b0;
      found          <= 1'b0;
      best_nonce     <= '0;
      best_hash      <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      done   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= v1_q;
      idx2_q <= iss_q;

      // Word 0 loads unconditionally; later words need a strict win so ties keep the lower index.
      if (v2_q && ((idx2_q == 8'd0) || (mem_read_data < best_hash))) begin
        best_hash  <= mem_read_data;
        best_nonce <= idx2_q;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            result_addr_q <= result_addr;
            target_q      <= target;
            mem_addr      <= hash_addr;
            mem_we        <= 1'b0;
            found         <= 1'b0;
            iss_q         <= '0;
            v1_q          <= 1'b1;
            state_q       <= (NUM_NONCES == 1) ? StDrain : StRead;
          end
        end
        StRead: begin
          iss_q    <= iss_q + 8'd1;
          mem_addr <= mem_addr + 16'd1;
          v1_q     <= 1'b1;
          if (iss_q + 8'd1 == LastIdx) state_q <= StDrain;
        end
        StDrain: begin
          if (v2_q && (idx2_q == LastIdx)) state_q <= StWrite;
        end
        StWrite: begin
          mem_we         <= 1'b1;
          mem_addr       <= result_addr_q;
          mem_write_data <= {found_next, 23'b0, best_nonce};
          found          <= found_next;
          state_q        <= StFin;
        end
        StFin: begin
          mem_we  <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_nonce_select.sv
// Table-driven bench with a two-cycle-latency memory model and a queue of
// expected scan results popped when done is seen.
module tb_bitcoin_nonce_select;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = '0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        done, found, mem_clk, mem_we;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash, mem_write_data, mem_read_data;
  logic [15:0] mem_addr;

  bitcoin_nonce_select #(.NUM_NONCES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr),
    .result_addr(result_addr), .target(target), .done(done), .found(found),
    .best_nonce(best_nonce), .best_hash(best_hash), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  int          wr_cnt = 0;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  assign mem_read_data = rd_q;

  always @(posedge clk) begin
    rd_q <= mem[mem_addr];
    if (mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_write_data;
    end
  end

  typedef struct {
    logic [15:0] haddr;
    logic [15:0] raddr;
    logic [31:0] tgt;
    int          pat;
    logic [7:0]  exp_nonce;
    logic [31:0] exp_hash;
    logic        exp_found;
  } vec_t;

  typedef struct {
    logic [7:0]  nonce;
    logic [31:0] hash;
    logic        found;
    logic [15:0] raddr;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int pat, input int i);
    case (pat)
      0:       return 32'hF000_0000 - 32'(i) * 32'h1000;
      1:       return (i == 3 || i == 9) ? 32'h5 : 32'h1000_0000 + 32'(i);
      2:       return 32'hFFFF_FFFF;
      default: return 32'h2000 - ((32'(i) * 32'd11) & 32'hF);
    endcase
  endfunction

  task automatic load_mem(input logic [15:0] haddr, input int pat);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = haddr + 16'(i);
      mem[a] = word_of(pat, i);
    end
  endtask

  task automatic run_scan(input vec_t v);
    exp_t e;
    int   w0, lat;
    e.nonce = v.exp_nonce;
    e.hash  = v.exp_hash;
    e.found = v.exp_found;
    e.raddr = v.raddr;
    sb_q.push_back(e);
    load_mem(v.haddr, v.pat);
    @(negedge clk);
    hash_addr = v.haddr; result_addr = v.raddr; target = v.tgt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs must have been captured on the start edge.
    hash_addr = 16'hDEAD; result_addr = 16'hBEEF; target = 32'h0000_0001;
    w0  = wr_cnt;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    e = sb_q.pop_front();
    check("latency", 32'(lat), 32'd19);
    check("best_nonce", {24'b0, best_nonce}, {24'b0, e.nonce});
    check("best_hash", best_hash, e.hash);
    check("found", {31'b0, found}, {31'b0, e.found});
    check("write_count", 32'(wr_cnt - w0), 32'd1);
    check("write_addr", {16'b0, wr_addr}, {16'b0, e.raddr});
    check("write_data", wr_data, {e.found, 23'b0, e.nonce});
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int w0, ndone, first_done, second_done;
    vecs[0] = '{16'h0100, 16'h0200, 32'hF000_0000, 0, 8'd15, 32'hEFFF_1000, 1'b1};
    vecs[1] = '{16'h0400, 16'h0500, 32'h0000_0010, 1, 8'd3,  32'h0000_0005, 1'b1};
    vecs[2] = '{16'h0600, 16'h0700, 32'h0000_1000, 2, 8'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{16'hFFF8, 16'h0800, 32'hFFFF_FFFF, 3, 8'd13, 32'h0000_1FF1, 1'b1};
    vecs[4] = '{16'h0900, 16'h0A00, 32'h0000_0000, 0, 8'd15, 32'hEFFF_1000, 1'b0};
    vecs[5] = '{16'h0B00, 16'h0C00, 32'hEFFF_1000, 0, 8'd15, 32'hEFFF_1000, 1'b0};
    vecs[6] = '{16'h0D00, 16'h0E00, 32'hEFFF_1001, 0, 8'd15, 32'hEFFF_1000, 1'b1};
    vecs[7] = '{16'h0F00, 16'h1000, 32'hFFFF_FFFF, 2, 8'd0,  32'hFFFF_FFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_found", {31'b0, found}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_hash", best_hash, 32'd0);
    check("rst_nonce", {24'b0, best_nonce}, 32'd0);
    check("mem_clk", {31'b0, mem_clk}, {31'b0, clk});
    @(negedge clk) reset_n = 1'b1;

    foreach (vecs[k]) run_scan(vecs[k]);

    // Results hold after done while inputs wander.
    target = 32'h0; hash_addr = 16'h1234;
    repeat (5) @(posedge clk);
    #1;
    check("hold_nonce", {24'b0, best_nonce}, 32'd0);
    check("hold_hash", best_hash, 32'hFFFF_FFFF);
    check("hold_found", {31'b0, found}, 32'd0);

    // Start pulsed again mid-scan is ignored.
    load_mem(16'h0100, 0);
    @(negedge clk);
    hash_addr = 16'h0100; result_addr = 16'h0200; target = 32'hF000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w0 = wr_cnt; ndone = 0; first_done = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
    end
    check("busy_done_count", 32'(ndone), 32'd1);
    check("busy_done_cycle", 32'(first_done), 32'd19);
    check("busy_writes", 32'(wr_cnt - w0), 32'd1);
    check("busy_nonce", {24'b0, best_nonce}, 32'd15);

    // Reset at cycle 8 aborts the scan.
    load_mem(16'h2000, 1);
    @(negedge clk);
    hash_addr = 16'h2000; result_addr = 16'h2100; target = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w0 = wr_cnt;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_done", 32'(ndone), 32'd0);
    check("abort_writes", 32'(wr_cnt - w0), 32'd0);
    check("abort_hash", best_hash, 32'd0);
    check("abort_addr", {16'b0, mem_addr}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    run_scan(vecs[1]);

    // Start held high: back-to-back scans.
    @(negedge clk);
    hash_addr = 16'h0100; result_addr = 16'h0200; target = 32'hF000_0000; start = 1'b1;
    @(posedge clk);
    ndone = 0; first_done = -1; second_done = -1;
    w0 = wr_cnt;
    for (int c = 1; c <= 39; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd2);
    check("held_first", 32'(first_done), 32'd19);
    check("held_second", 32'(second_done), 32'd39);
    check("held_writes", 32'(wr_cnt - w0), 32'd2);
    check("held_data", wr_data, 32'h8000_000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
